// File: rtl/bench_pkg.sv
// rtl/bench_pkg.sv - shared constants and types for the benchmark result UART transmitter
// BENCH_TX_CHECKSUM_EN selects the 29-byte frame with a trailing XOR checksum.
package bench_pkg;

  localparam logic [7:0] BENCH_SYNC_BYTE = 8'hA5;
  localparam int         BENCH_DATA_LEN  = 28;

`ifdef BENCH_TX_CHECKSUM_EN
  localparam int BENCH_FRAME_LEN = 29;
`else
  localparam int BENCH_FRAME_LEN = 28;
`endif

  localparam logic [4:0] BYTE_SYNC   = 5'd0;
  localparam logic [4:0] BYTE_WINNER = 5'd1;
  localparam logic [4:0] BYTE_OPS    = 5'd2;
  localparam logic [4:0] BYTE_TCOND0 = 5'd4;
  localparam logic [4:0] BYTE_TTOTAL = 5'd24;
  localparam logic [4:0] BYTE_CSUM   = 5'd28;
  localparam logic [4:0] BYTE_END    = 5'(BENCH_FRAME_LEN);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with valid/ready and a DIV-cycle bit timer
// A byte offered during the last STOP cycle follows with no idle gap.
module uart_tx_byte
  import bench_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [7:0] tdata,
  input  logic       tvalid,
  output logic       tready,
  output logic       stop_done,
  output logic       tx
);

  localparam int             CW       = $clog2(DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  tx_state_t     state, state_nxt;
  logic [CW-1:0] div_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;
  logic          load;

  assign bit_end   = (div_cnt == DIV_LAST);
  assign stop_done = (state == STOP) && bit_end;
  assign tready    = (state == IDLE) || stop_done;
  assign load      = tvalid && tready;

  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    case (state)
      IDLE:  if (tvalid) state_nxt = START;
      START: begin
        tx = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx = shreg[0];
        if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
      end
      STOP:  if (bit_end) state_nxt = tvalid ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      state <= state_nxt;
      if (load) begin
        shreg   <= tdata;
        div_cnt <= '0;
        bit_idx <= 3'd0;
      end else if (state != IDLE) begin
        div_cnt <= bit_end ? '0 : div_cnt + 1'b1;
        if (state == DATA && bit_end) begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bench_result_uart_tx.sv
// rtl/bench_result_uart_tx.sv - snapshots bench engine results on done rise and sends them as one UART frame
// BENCH_TX_CHECKSUM_EN appends an XOR checksum of bytes 1..27 as byte 28.
module bench_result_uart_tx
  import bench_pkg::*;
#(
  parameter int CLK_HZ = 125_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        done,
  input  logic [2:0]  winner_code,
  input  logic [15:0] ops_per_condition,
  input  logic [31:0] t_cond0,
  input  logic [31:0] t_cond1,
  input  logic [31:0] t_cond2,
  input  logic [31:0] t_cond3,
  input  logic [31:0] t_cond4,
  input  logic [31:0] t_total,
  output logic        uart_tx,
  output logic        busy,
  output logic        frame_sent,
  output logic        overrun
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int SW  = BENCH_DATA_LEN * 8;

  logic          done_d;
  logic          rise, accept;
  logic          tvalid, tready, stop_done, all_loaded;
  logic [4:0]    byte_idx;
  logic [SW-1:0] snap, snap_shift;
  logic [7:0]    cur_byte;
`ifdef BENCH_TX_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  assign rise       = done & ~done_d;
  assign all_loaded = (byte_idx == BYTE_END);
  assign tvalid     = busy & ~all_loaded;
  assign frame_sent = busy & all_loaded & stop_done;
  assign accept     = rise & (~busy | frame_sent);

  // Snapshot is stored in wire order, so the next byte is always the top octet after shifting.
  assign snap_shift = snap << {byte_idx, 3'b000};

  always_comb begin
    cur_byte = snap_shift[SW-1 -: 8];
`ifdef BENCH_TX_CHECKSUM_EN
    if (byte_idx == BYTE_CSUM) cur_byte = csum;
`endif
  end

  always_ff @(posedge sysclk) begin
    if (accept) begin
      snap <= {BENCH_SYNC_BYTE, 5'b0, winner_code, ops_per_condition,
               t_cond0, t_cond1, t_cond2, t_cond3, t_cond4, t_total};
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      done_d   <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      byte_idx <= 5'd0;
`ifdef BENCH_TX_CHECKSUM_EN
      csum     <= 8'd0;
`endif
    end else begin
      done_d <= done;
      if (rise && busy && !frame_sent) overrun <= 1'b1;
      if (accept) begin
        busy     <= 1'b1;
        byte_idx <= 5'd0;
`ifdef BENCH_TX_CHECKSUM_EN
        csum     <= 8'd0;
`endif
      end else begin
        if (frame_sent) busy <= 1'b0;
        if (tvalid && tready) begin
          byte_idx <= byte_idx + 5'd1;
`ifdef BENCH_TX_CHECKSUM_EN
          if (byte_idx != BYTE_SYNC && byte_idx != BYTE_CSUM) csum <= csum ^ cur_byte;
`endif
        end
      end
    end
  end

  uart_tx_byte #(.DIV(DIV)) u_ser (
    .sysclk    (sysclk),
    .rst       (rst),
    .tdata     (cur_byte),
    .tvalid    (tvalid),
    .tready    (tready),
    .stop_done (stop_done),
    .tx        (uart_tx)
  );

endmodule

// File: tb/tb_bench_result_uart_tx.sv
// tb/tb_bench_result_uart_tx.sv - directed bench for bench_result_uart_tx with a host-side UART decoder
module tb_bench_result_uart_tx;

  localparam int DIV      = 10;
  localparam int BYTE_CYC = 10 * DIV;
`ifdef BENCH_TX_CHECKSUM_EN
  localparam int FLEN = 29;
`else
  localparam int FLEN = 28;
`endif

  typedef logic [7:0] bytes_t[$];

  logic        sysclk = 1'b0;
  logic        rst = 1'b1;
  logic        done = 1'b0;
  logic [2:0]  winner_code = 3'd0;
  logic [15:0] ops_per_condition = 16'd0;
  logic [31:0] t_cond0 = 0, t_cond1 = 0, t_cond2 = 0, t_cond3 = 0, t_cond4 = 0, t_total = 0;
  logic        uart_tx, busy, frame_sent, overrun;

  always #5 sysclk = ~sysclk;

  bench_result_uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .sysclk            (sysclk),
    .rst               (rst),
    .done              (done),
    .winner_code       (winner_code),
    .ops_per_condition (ops_per_condition),
    .t_cond0           (t_cond0),
    .t_cond1           (t_cond1),
    .t_cond2           (t_cond2),
    .t_cond3           (t_cond3),
    .t_cond4           (t_cond4),
    .t_total           (t_total),
    .uart_tx           (uart_tx),
    .busy              (busy),
    .frame_sent        (frame_sent),
    .overrun           (overrun)
  );

  int     cyc = 0;
  int     n_checks = 0;
  int     n_errors = 0;
  bytes_t rx_q;
  int     start_q[$];
  int     framing_err = 0;
  int     fs_count = 0;
  logic [7:0] mon_byte;
  bytes_t exp1, exp_b;
  int     bcyc, fall, fsc, fsb;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) if (frame_sent === 1'b1) fs_count++;

  // Host decoder: samples each bit in its middle, then realigns to the end of the stop bit.
  initial forever begin
    @(negedge sysclk);
    if (uart_tx === 1'b0) begin
      start_q.push_back(cyc);
      repeat (4) @(negedge sysclk);
      if (uart_tx !== 1'b0) framing_err++;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge sysclk);
        mon_byte[i] = uart_tx;
      end
      repeat (DIV) @(negedge sysclk);
      if (uart_tx !== 1'b1) framing_err++;
      rx_q.push_back(mon_byte);
      repeat (5) @(negedge sysclk);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bytes_t make_frame(input logic [2:0] w, input logic [15:0] ops,
                                        input logic [31:0] a0, a1, a2, a3, a4, tt);
    bytes_t      f;
    logic [31:0] tc[6];
    logic [7:0]  cs;
    f.push_back(8'hA5);
    f.push_back({5'b0, w});
    f.push_back(ops[15:8]);
    f.push_back(ops[7:0]);
    tc = '{a0, a1, a2, a3, a4, tt};
    for (int k = 0; k < 6; k++)
      for (int j = 3; j >= 0; j--) f.push_back(tc[k][8*j +: 8]);
    cs = 8'd0;
    for (int i = 1; i < 28; i++) cs = cs ^ f[i];
`ifdef BENCH_TX_CHECKSUM_EN
    f.push_back(cs);
`endif
    return f;
  endfunction

  task automatic check_frame(input string tag, input int base, input bytes_t exp);
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i),
            (base + i < rx_q.size()) ? 32'(rx_q[base + i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  task automatic set_case1;
    winner_code = 3'd3; ops_per_condition = 16'h1234;
    t_cond0 = 32'h100; t_cond1 = 32'h101; t_cond2 = 32'h102;
    t_cond3 = 32'h103; t_cond4 = 32'h104; t_total = 32'h514;
  endtask

  task automatic set_case_b;
    winner_code = 3'd1; ops_per_condition = 16'hBEEF;
    t_cond0 = 32'hDEAD_BEEF; t_cond1 = 32'h0123_4567; t_cond2 = 32'h89AB_CDEF;
    t_cond3 = 32'hFFFF_FFFF; t_cond4 = 32'h0; t_total = 32'h8000_0001;
  endtask

  task automatic do_reset;
    @(posedge sysclk); #1 rst = 1'b1;
    repeat (3) @(posedge sysclk);
    #1 rst = 1'b0;
    rx_q.delete(); start_q.delete();
    fs_count = 0; framing_err = 0;
  endtask

  task automatic send_done;
    @(posedge sysclk); #1 done = 1'b1;
    repeat (3) @(posedge sysclk);
    #1 done = 1'b0;
  endtask

  task automatic wait_idle(output int fall_cyc);
    for (int k = 0; k < 6000; k++) begin
      @(negedge sysclk);
      if (busy === 1'b0) break;
    end
    fall_cyc = cyc;
    if (busy !== 1'b0) check("busy_fall_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_bytes(input int n);
    for (int k = 0; k < 8000; k++) begin
      if (rx_q.size() >= n) break;
      @(negedge sysclk);
    end
    if (rx_q.size() < n) check("byte_wait_timeout", 32'(rx_q.size()), 32'(n));
  endtask

  initial begin
    exp1 = '{8'hA5, 8'h03, 8'h12, 8'h34,
             8'h00, 8'h00, 8'h01, 8'h00,  8'h00, 8'h00, 8'h01, 8'h01,
             8'h00, 8'h00, 8'h01, 8'h02,  8'h00, 8'h00, 8'h01, 8'h03,
             8'h00, 8'h00, 8'h01, 8'h04,  8'h00, 8'h00, 8'h05, 8'h14};
`ifdef BENCH_TX_CHECKSUM_EN
    exp1.push_back(8'h31);
`endif
    exp_b = make_frame(3'd1, 16'hBEEF, 32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF,
                       32'hFFFF_FFFF, 32'h0, 32'h8000_0001);

    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_sent", 32'(frame_sent), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(posedge sysclk); #1 rst = 1'b0;

    // Basic frame, timing and frame length
    set_case1();
    @(posedge sysclk); #1 done = 1'b1;
    bcyc = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge sysclk);
      if (busy === 1'b1) begin bcyc = cyc; break; end
    end
    check("busy_rise", 32'(busy), 32'd1);
    @(posedge sysclk); #1 done = 1'b0;
    wait_idle(fall);
    repeat (20) @(negedge sysclk);
    check("t1_len", 32'(rx_q.size()), 32'(FLEN));
    check_frame("t1", 0, exp1);
    if (start_q.size() == FLEN) begin
      check("t1_start_latency", 32'(start_q[0]), 32'(bcyc + 1));
      check("t1_last_start", 32'(start_q[FLEN-1]), 32'(start_q[0] + (FLEN - 1) * BYTE_CYC));
      check("t1_busy_fall", 32'(fall), 32'(start_q[0] + FLEN * BYTE_CYC));
    end
    check("t1_frame_sent_count", 32'(fs_count), 32'd1);
    check("t1_overrun", 32'(overrun), 32'd0);
    check("t1_framing", 32'(framing_err), 32'd0);

    // Overrun: second rise during byte 10 is dropped
    do_reset();
    set_case1();
    send_done();
    wait_bytes(10);
    set_case_b();
    send_done();
    repeat (2) @(negedge sysclk);
    check("t3_overrun", 32'(overrun), 32'd1);
    wait_idle(fall);
    repeat (300) @(negedge sysclk);
    check("t3_len", 32'(rx_q.size()), 32'(FLEN));
    check_frame("t3", 0, exp1);
    check("t3_frame_sent_count", 32'(fs_count), 32'd1);

    // Back-to-back: rise in the frame_sent cycle
    do_reset();
    set_case1();
    send_done();
    fsc = -1;
    for (int k = 0; k < 6000; k++) begin
      @(negedge sysclk);
      if (frame_sent === 1'b1) begin fsc = cyc; break; end
    end
    check("t4_frame_sent_seen", 32'(frame_sent), 32'd1);
    set_case_b();
    done = 1'b1;
    repeat (3) @(posedge sysclk);
    #1 done = 1'b0;
    wait_bytes(2 * FLEN);
    wait_idle(fall);
    repeat (20) @(negedge sysclk);
    check("t4_len", 32'(rx_q.size()), 32'(2 * FLEN));
    if (start_q.size() > FLEN) check("t4_restart_gap", 32'(start_q[FLEN]), 32'(fsc + 2));
    check("t4_overrun", 32'(overrun), 32'd0);
    check("t4_frame_sent_count", 32'(fs_count), 32'd2);
    check_frame("t4a", 0, exp1);
    check_frame("t4b", FLEN, exp_b);

    // Mid-frame reset during a data bit of byte 5
    do_reset();
    set_case1();
    send_done();
    wait_bytes(5);
    repeat (40) @(posedge sysclk);
    #1 rst = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    check("t5_rst_tx", 32'(uart_tx), 32'd1);
    check("t5_rst_busy", 32'(busy), 32'd0);
    fsb = fs_count;
    @(posedge sysclk); #1 rst = 1'b0;
    repeat (300) @(negedge sysclk);
    check("t5_no_frame_sent", 32'(fs_count), 32'(fsb));
    check("t5_stay_idle", 32'(busy), 32'd0);
    rx_q.delete(); start_q.delete(); framing_err = 0;
    set_case_b();
    send_done();
    wait_idle(fall);
    repeat (20) @(negedge sysclk);
    check("t5_len", 32'(rx_q.size()), 32'(FLEN));
    check_frame("t5", 0, exp_b);
    check("t5_frame_sent_count", 32'(fs_count), 32'(fsb + 1));
    check("t5_framing", 32'(framing_err), 32'd0);

    // Level hold: done high for 1000 cycles yields one frame
    do_reset();
    set_case1();
    @(posedge sysclk); #1 done = 1'b1;
    repeat (1000) @(posedge sysclk);
    #1 done = 1'b0;
    wait_idle(fall);
    repeat (300) @(negedge sysclk);
    check("t6_len", 32'(rx_q.size()), 32'(FLEN));
    check_frame("t6", 0, exp1);
    check("t6_frame_sent_count", 32'(fs_count), 32'd1);
    check("t6_overrun", 32'(overrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
